// File: rtl/prog_loader_if.sv
// Stream-in and memory-write bundle for the boot loader.
// The master side is the loader; the slave side is the byte source and memory.
interface prog_loader_if #(
  parameter int DATA_WIDTH = 32,
  parameter int LEN_W      = 8
);
  logic                  start;
  logic [LEN_W-1:0]      len;
  logic [7:0]            byte_in;
  logic                  byte_valid;
  logic                  byte_ready;
  logic [DATA_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  busy;
  logic                  done;
  logic                  error;
  logic                  cpu_rst_n;

  modport master (
    input  start, len, byte_in, byte_valid, mem_rdata,
    output byte_ready, mem_addr, mem_wdata, mem_we, busy, done, error, cpu_rst_n
  );

  modport slave (
    output start, len, byte_in, byte_valid, mem_rdata,
    input  byte_ready, mem_addr, mem_wdata, mem_we, busy, done, error, cpu_rst_n
  );
endinterface

// File: rtl/prog_loader.sv
// Boot loader: packs a little-endian byte stream into words, writes them to memory,
// reads them back against a trailing checksum and releases the CPU reset on success.
module prog_loader #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 200,
  parameter int LEN_W      = 8
) (
  input  logic          clk,
  input  logic          rst,
  prog_loader_if.master bus
);

  typedef enum logic [2:0] {IDLE, RECV, WRITE, CSUM, VERIFY, CHECK, DONE, ERR} state_t;

  localparam logic [LEN_W:0] DEPTH_MAX = (LEN_W+1)'(DEPTH);

  state_t                state_q, state_d;
  logic [LEN_W-1:0]      len_q, len_d;
  logic [LEN_W-1:0]      idx_q, idx_d;
  logic [1:0]            bcnt_q, bcnt_d;
  logic [DATA_WIDTH-1:0] word_q, word_d;
  logic [DATA_WIDTH-1:0] rsum_q, rsum_d;
  logic [DATA_WIDTH-1:0] vsum_q, vsum_d;

  logic ready, take, len_bad;

  assign ready   = (state_q == RECV) || (state_q == CSUM);
  assign take    = ready && bus.byte_valid;
  assign len_bad = (bus.len == '0) || ({1'b0, bus.len} > DEPTH_MAX);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      len_q   <= '0;
      idx_q   <= '0;
      bcnt_q  <= '0;
      word_q  <= '0;
      rsum_q  <= '0;
      vsum_q  <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      bcnt_q  <= bcnt_d;
      word_q  <= word_d;
      rsum_q  <= rsum_d;
      vsum_q  <= vsum_d;
    end
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    bcnt_d  = bcnt_q;
    word_d  = word_q;
    rsum_d  = rsum_q;
    vsum_d  = vsum_q;
    case (state_q)
      IDLE, DONE, ERR: begin
        if (bus.start) begin
          len_d   = bus.len;
          idx_d   = '0;
          bcnt_d  = '0;
          word_d  = '0;
          rsum_d  = '0;
          vsum_d  = '0;
          state_d = len_bad ? ERR : RECV;
        end
      end
      // word_q shifts right so the first byte lands in [7:0]; in CSUM it
      // is reused to hold the expected checksum once all data is written.
      RECV, CSUM: begin
        if (take) begin
          word_d = {bus.byte_in, word_q[DATA_WIDTH-1:8]};
          bcnt_d = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) begin
            if (state_q == RECV) begin
              state_d = WRITE;
            end else begin
              idx_d   = '0;
              state_d = VERIFY;
            end
          end
        end
      end
      WRITE: begin
        rsum_d  = rsum_q + word_q;
        idx_d   = idx_q + 1'b1;
        state_d = (idx_d == len_q) ? CSUM : RECV;
      end
      VERIFY: begin
        vsum_d = vsum_q + bus.mem_rdata;
        idx_d  = idx_q + 1'b1;
        if (idx_q == len_q - 1'b1) state_d = CHECK;
      end
      CHECK: begin
        state_d = ((rsum_q == word_q) && (vsum_q == word_q)) ? DONE : ERR;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.byte_ready = ready;
    bus.mem_we     = (state_q == WRITE);
    bus.mem_addr   = '0;
    bus.mem_wdata  = '0;
    bus.busy       = 1'b0;
    bus.done       = 1'b0;
    bus.error      = 1'b0;
    bus.cpu_rst_n  = 1'b0;
    case (state_q)
      RECV, CSUM, CHECK: bus.busy = 1'b1;
      WRITE: begin
        bus.busy      = 1'b1;
        bus.mem_addr  = DATA_WIDTH'(idx_q);
        bus.mem_wdata = word_q;
      end
      VERIFY: begin
        bus.busy     = 1'b1;
        bus.mem_addr = DATA_WIDTH'(idx_q);
      end
      DONE: begin
        bus.done      = 1'b1;
        bus.cpu_rst_n = 1'b1;
      end
      ERR:     bus.error = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: memory model on the write/read port, write scoreboard,
// and one task per scenario.
module tb_prog_loader;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  prog_loader_if bif ();

  prog_loader dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  logic [31:0] mem [0:255];
  logic [63:0] exp_q[$];
  logic [63:0] obs_q[$];
  int          we_cnt = 0;
  int          total  = 0;
  int          bad    = 0;
  logic [31:0] prog [0:1] = '{32'h0000_0013, 32'h00A0_0093};

  assign bif.mem_rdata = mem[bif.mem_addr[7:0]];

  always @(posedge clk) begin
    if (bif.mem_we) begin
      mem[bif.mem_addr[7:0]] <= bif.mem_wdata;
      obs_q.push_back({bif.mem_addr, bif.mem_wdata});
      we_cnt <= we_cnt + 1;
    end
  end

  task automatic pulse_start(input logic [7:0] n);
    @(negedge clk);
    bif.start = 1'b1;
    bif.len   = n;
    @(negedge clk);
    bif.start = 1'b0;
  endtask

  // Offer one byte until accepted; rnd randomises byte_valid every cycle.
  task automatic send_byte(input logic [7:0] b, input bit rnd);
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      bif.byte_in    = b;
      bif.byte_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (bif.byte_valid && bif.byte_ready) return;
    end
    total++;
    bad++;
    $display("FAIL byte_accept timeout byte=%02h", b);
  endtask

  task automatic wait_end();
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      if (bif.done || bif.error) return;
    end
    total++;
    bad++;
    $display("FAIL load_end timeout done=%b error=%b", bif.done, bif.error);
  endtask

  task automatic run_load(input int n, input logic [31:0] csum, input bit rnd, input bit corrupt);
    logic [31:0] w;
    pulse_start(8'(n));
    for (int i = 0; i < n; i++) begin
      w = prog[i];
      exp_q.push_back({32'(i), w});
      for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], rnd);
    end
    @(negedge clk);
    bif.byte_valid = 1'b0;
    if (corrupt) begin
      @(negedge clk);
      mem[1] = 32'h0;
    end
    for (int k = 0; k < 4; k++) send_byte(csum[8*k +: 8], rnd);
    @(negedge clk);
    bif.byte_valid = 1'b0;
    wait_end();
  endtask

  task automatic test_reset();
    #23;
    total++;
    if ({bif.busy, bif.done, bif.error, bif.cpu_rst_n, bif.byte_ready, bif.mem_we} !== 6'b0) begin
      bad++;
      $display("FAIL reset_ctrl got=%b exp=000000",
               {bif.busy, bif.done, bif.error, bif.cpu_rst_n, bif.byte_ready, bif.mem_we});
    end
    total++;
    if (bif.mem_addr !== 32'h0) begin bad++; $display("FAIL reset_addr got=%h exp=0", bif.mem_addr); end
    total++;
    if (bif.mem_wdata !== 32'h0) begin bad++; $display("FAIL reset_wdata got=%h exp=0", bif.mem_wdata); end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_basic();
    logic [63:0] e, o;
    run_load(2, 32'h00A0_00A6, 1'b0, 1'b0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 64'hx;
      total++;
      if (o !== e) begin bad++; $display("FAIL t1_write got=%h exp=%h", o, e); end
    end
    total++;
    if (obs_q.size() != 0) begin bad++; $display("FAIL t1_extra got=%0d exp=0", obs_q.size()); obs_q.delete(); end
    total++;
    if (mem[0] !== 32'h0000_0013) begin bad++; $display("FAIL t1_mem0 got=%h exp=00000013", mem[0]); end
    total++;
    if (mem[1] !== 32'h00A0_0093) begin bad++; $display("FAIL t1_mem1 got=%h exp=00a00093", mem[1]); end
    total++;
    if ({bif.done, bif.error, bif.cpu_rst_n, bif.busy} !== 4'b1010) begin
      bad++;
      $display("FAIL t1_status got=%b exp=1010", {bif.done, bif.error, bif.cpu_rst_n, bif.busy});
    end
    repeat (3) @(negedge clk);
    total++;
    if (bif.done !== 1'b1) begin bad++; $display("FAIL t1_done_hold got=%b exp=1", bif.done); end
  endtask

  task automatic test_len_err();
    int we0;
    we0 = we_cnt;
    pulse_start(8'd0);
    total++;
    if ({bif.error, bif.done, bif.busy, bif.cpu_rst_n} !== 4'b1000) begin
      bad++;
      $display("FAIL t3_len0 got=%b exp=1000", {bif.error, bif.done, bif.busy, bif.cpu_rst_n});
    end
    pulse_start(8'd201);
    total++;
    if ({bif.error, bif.done, bif.busy} !== 3'b100) begin
      bad++;
      $display("FAIL t3_len201 got=%b exp=100", {bif.error, bif.done, bif.busy});
    end
    pulse_start(8'd200);
    total++;
    if ({bif.error, bif.busy, bif.byte_ready} !== 3'b011) begin
      bad++;
      $display("FAIL t3_len200_ok got=%b exp=011", {bif.error, bif.busy, bif.byte_ready});
    end
    pulse_start(8'd0);
    total++;
    if (bif.busy !== 1'b1) begin bad++; $display("FAIL t3_start_ignored busy got=%b exp=1", bif.busy); end
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    total++;
    if (we_cnt != we0) begin bad++; $display("FAIL t3_no_write got=%0d exp=%0d", we_cnt, we0); end
  endtask

  task automatic test_bad_csum();
    logic [63:0] e, o;
    run_load(2, 32'h01A0_00A6, 1'b0, 1'b0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 64'hx;
      total++;
      if (o !== e) begin bad++; $display("FAIL t2_write got=%h exp=%h", o, e); end
    end
    obs_q.delete();
    total++;
    if ({bif.error, bif.done, bif.cpu_rst_n} !== 3'b100) begin
      bad++;
      $display("FAIL t2_status got=%b exp=100", {bif.error, bif.done, bif.cpu_rst_n});
    end
  endtask

  task automatic test_random_valid();
    logic [63:0] e, o;
    mem[0] = 32'hDEAD_BEEF;
    mem[1] = 32'hDEAD_BEEF;
    run_load(2, 32'h00A0_00A6, 1'b1, 1'b0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 64'hx;
      total++;
      if (o !== e) begin bad++; $display("FAIL t4_write got=%h exp=%h", o, e); end
    end
    total++;
    if (obs_q.size() != 0) begin bad++; $display("FAIL t4_extra got=%0d exp=0", obs_q.size()); obs_q.delete(); end
    total++;
    if ({mem[1], mem[0]} !== 64'h00A0_0093_0000_0013) begin
      bad++;
      $display("FAIL t4_mem got=%h exp=00a0009300000013", {mem[1], mem[0]});
    end
    total++;
    if ({bif.done, bif.error, bif.cpu_rst_n} !== 3'b101) begin
      bad++;
      $display("FAIL t4_status got=%b exp=101", {bif.done, bif.error, bif.cpu_rst_n});
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] bytes [0:4];
    bytes = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93};
    pulse_start(8'd2);
    for (int i = 0; i < 5; i++) send_byte(bytes[i], 1'b0);
    @(negedge clk);
    bif.byte_valid = 1'b0;
    rst = 1'b0;
    #1;
    total++;
    if ({bif.busy, bif.done, bif.error, bif.cpu_rst_n, bif.byte_ready, bif.mem_we} !== 6'b0) begin
      bad++;
      $display("FAIL t5_rst_ctrl got=%b exp=000000",
               {bif.busy, bif.done, bif.error, bif.cpu_rst_n, bif.byte_ready, bif.mem_we});
    end
    total++;
    if ({bif.mem_addr, bif.mem_wdata} !== 64'h0) begin
      bad++;
      $display("FAIL t5_rst_bus got=%h exp=0", {bif.mem_addr, bif.mem_wdata});
    end
    total++;
    if (obs_q.size() != 1) begin bad++; $display("FAIL t5_partial_writes got=%0d exp=1", obs_q.size()); end
    obs_q.delete();
    exp_q.delete();
    @(negedge clk);
    rst = 1'b1;
    run_load(2, 32'h00A0_00A6, 1'b0, 1'b0);
    total++;
    if (obs_q.size() != 2) begin bad++; $display("FAIL t5_rerun_writes got=%0d exp=2", obs_q.size()); end
    obs_q.delete();
    exp_q.delete();
    total++;
    if ({bif.done, bif.error, bif.cpu_rst_n} !== 3'b101) begin
      bad++;
      $display("FAIL t5_status got=%b exp=101", {bif.done, bif.error, bif.cpu_rst_n});
    end
  endtask

  task automatic test_readback_err();
    logic [63:0] e, o;
    run_load(2, 32'h00A0_00A6, 1'b0, 1'b1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 64'hx;
      total++;
      if (o !== e) begin bad++; $display("FAIL t6_write got=%h exp=%h", o, e); end
    end
    obs_q.delete();
    total++;
    if ({bif.error, bif.done, bif.cpu_rst_n} !== 3'b100) begin
      bad++;
      $display("FAIL t6_status got=%b exp=100", {bif.error, bif.done, bif.cpu_rst_n});
    end
  endtask

  initial begin
    rst            = 1'b0;
    bif.start      = 1'b0;
    bif.len        = '0;
    bif.byte_in    = '0;
    bif.byte_valid = 1'b0;
    test_reset();
    test_basic();
    test_len_err();
    test_bad_csum();
    test_random_valid();
    test_reset_mid();
    test_readback_err();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
